// File: rtl/tanimoto_top_intf.sv
// tanimoto_top_intf
// Streaming fingerprint-similarity filter. A byte-packed stream of VECTOR_WIDTH-bit
// vectors arrives on S_AXIS_DATA. The first SHR_DEPTH vectors of each stream are
// reference vectors. Each later (compare) vector is tested against every reference,
// and the pair {ref id, compare id} of every match is emitted on M_AXIS_ID_PAIR.
// The match rule is pr + pc <= thr[popcount(ref & cmp)], where pr and pc are the
// popcounts of the reference and compare vectors. thr is loaded through a
// BRAM-style port. Every stream ends with an all-ones terminator word that has
// tlast=1.
//
// Ports
//   ap_clk, ap_rstn         clock, synchronous active-low reset
//   S_AXIS_DATA_*           input vector stream (tdata/tvalid/tready/tlast)
//   M_AXIS_ID_PAIR_*        output match stream, tdata = {ref id, compare id}
//   BRAM_PORTA_*            threshold table access port; clk_a is tied to ap_clk
//
// FSM
//   state    | meaning
//   LOAD_REF | completed vectors are stored as references
//   COMPARE  | completed vectors are evaluated against all references
module tanimoto_top_intf #(
  parameter int BUS_WIDTH      = 128,
  parameter int VECTOR_WIDTH   = 920,
  parameter int SHR_DEPTH      = 8,
  parameter int SUB_VECTOR_NO  = 8,
  parameter int GRANULE_WIDTH  = 6,
  parameter int VEC_ID_WIDTH   = 8,
  parameter int OUT_FIFO_DEPTH = 16,
  parameter int CNT_WIDTH      = $clog2(VECTOR_WIDTH)
) (
  input  logic                      ap_clk,
  input  logic                      ap_rstn,
  input  logic [BUS_WIDTH-1:0]      S_AXIS_DATA_tdata,
  input  logic                      S_AXIS_DATA_tvalid,
  output logic                      S_AXIS_DATA_tready,
  input  logic                      S_AXIS_DATA_tlast,
  output logic [2*VEC_ID_WIDTH-1:0] M_AXIS_ID_PAIR_tdata,
  output logic                      M_AXIS_ID_PAIR_tvalid,
  input  logic                      M_AXIS_ID_PAIR_tready,
  output logic                      M_AXIS_ID_PAIR_tlast,
  input  logic                      BRAM_PORTA_clk_a,
  input  logic                      BRAM_PORTA_rst_a,
  input  logic [CNT_WIDTH-1:0]      BRAM_PORTA_addr_a,
  input  logic [CNT_WIDTH:0]        BRAM_PORTA_wrdata_a,
  output logic [CNT_WIDTH:0]        BRAM_PORTA_rddata_a,
  input  logic                      BRAM_PORTA_en_a,
  input  logic                      BRAM_PORTA_we_a
);

  localparam int BUF_W   = VECTOR_WIDTH + BUS_WIDTH;
  localparam int FILL_W  = $clog2(BUF_W + 1);
  localparam int KW      = (SHR_DEPTH > 1) ? $clog2(SHR_DEPTH) : 1;
  localparam int SLICE_W = VECTOR_WIDTH / SUB_VECTOR_NO;
  localparam int NGRAN   = (SLICE_W + GRANULE_WIDTH - 1) / GRANULE_WIDTH;
  localparam int PW      = CNT_WIDTH + 1;
  localparam int OW      = 2 * VEC_ID_WIDTH;
  localparam int FCW     = $clog2(OUT_FIFO_DEPTH + 1);
  localparam int FAW     = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;

  typedef enum logic {LOAD_REF, COMPARE} state_t;

  // Popcount built as SUB_VECTOR_NO slice sums, each slice summed from
  // GRANULE_WIDTH-bit leaves; the last leaf of a slice may be partial.
  function automatic logic [PW-1:0] f_popcount(input logic [VECTOR_WIDTH-1:0] v);
    logic [PW-1:0] total;
    logic [PW-1:0] slice_sum;
    logic [PW-1:0] leaf;
    int            idx;
    total = '0;
    for (int s = 0; s < SUB_VECTOR_NO; s++) begin
      slice_sum = '0;
      for (int g = 0; g < NGRAN; g++) begin
        leaf = '0;
        for (int b = 0; b < GRANULE_WIDTH; b++) begin
          idx = s * SLICE_W + g * GRANULE_WIDTH + b;
          if (g * GRANULE_WIDTH + b < SLICE_W) leaf = leaf + PW'(v[idx]);
        end
        slice_sum = slice_sum + leaf;
      end
      total = total + slice_sum;
    end
    return total;
  endfunction

  // Threshold table and BRAM port
  logic [CNT_WIDTH:0] r_thr [0:(1<<CNT_WIDTH)-1];
  logic [CNT_WIDTH:0] r_rddata;

  always_ff @(posedge BRAM_PORTA_clk_a) begin
    if (BRAM_PORTA_en_a && BRAM_PORTA_we_a) r_thr[BRAM_PORTA_addr_a] <= BRAM_PORTA_wrdata_a;
  end

  always_ff @(posedge BRAM_PORTA_clk_a) begin
    if (!ap_rstn || BRAM_PORTA_rst_a) r_rddata <= '0;
    else if (BRAM_PORTA_en_a)         r_rddata <= r_thr[BRAM_PORTA_addr_a];
  end

  assign BRAM_PORTA_rddata_a = r_rddata;

  // State and datapath registers
  state_t                  r_state, w_state_nxt;
  logic [BUF_W-1:0]        r_buf;
  logic [FILL_W-1:0]       r_fill;
  logic                    r_eos;
  logic                    r_run;
  logic [VECTOR_WIDTH-1:0] r_ref [SHR_DEPTH];
  logic [PW-1:0]           r_pr  [SHR_DEPTH];
  logic [KW-1:0]           r_ref_idx;
  logic [VECTOR_WIDTH-1:0] r_cmp;
  logic [PW-1:0]           r_pc;
  logic                    r_busy;
  logic [KW-1:0]           r_k;
  logic [VEC_ID_WIDTH-1:0] r_cur_id, r_next_id;
  logic [OW:0]             r_fifo_mem [OUT_FIFO_DEPTH];
  logic [FCW-1:0]          r_fifo_cnt;

  logic [VECTOR_WIDTH-1:0] w_vec;
  logic [PW-1:0]           w_vec_pc, w_i, w_thr, w_sum;
  logic                    w_vec_avail, w_fifo_full, w_fifo_pop, w_can_push;
  logic                    w_match, w_eval_adv, w_eval_last, w_vec_pop;
  logic                    w_term_push, w_beat_acc, w_push;
  logic [OW:0]             w_push_data, w_head;
  logic [FAW-1:0]          w_head_idx;

  assign w_vec       = r_buf[VECTOR_WIDTH-1:0];
  assign w_vec_pc    = f_popcount(w_vec);
  assign w_vec_avail = (r_fill >= FILL_W'(VECTOR_WIDTH));

  assign w_fifo_full = (r_fifo_cnt == FCW'(OUT_FIFO_DEPTH));
  assign w_fifo_pop  = M_AXIS_ID_PAIR_tvalid && M_AXIS_ID_PAIR_tready;
  // A full FIFO still accepts a push in the cycle it is being popped.
  assign w_can_push  = !w_fifo_full || M_AXIS_ID_PAIR_tready;

  assign w_i   = f_popcount(r_ref[r_k] & r_cmp);
  assign w_thr = r_thr[w_i[CNT_WIDTH-1:0]];
  assign w_sum = r_pr[r_k] + r_pc;

  // An intersection count beyond the table range never matches.
  assign w_match     = r_busy && !w_i[CNT_WIDTH] && (w_sum <= w_thr);
  assign w_eval_adv  = r_busy && (!w_match || w_can_push);
  assign w_eval_last = w_eval_adv && (r_k == KW'(SHR_DEPTH - 1));

  // The next vector may enter while the last reference of the previous one is evaluated.
  assign w_vec_pop   = w_vec_avail && ((r_state == LOAD_REF) || !r_busy || w_eval_last);
  assign w_term_push = r_eos && !w_vec_avail && !r_busy && w_can_push;

  // Accepting a beat only while less than one vector is buffered keeps the fill
  // at or below VECTOR_WIDTH-8+BUS_WIDTH, so the buffer cannot overflow.
  assign S_AXIS_DATA_tready = r_run && !r_eos && !w_vec_avail;
  assign w_beat_acc         = S_AXIS_DATA_tvalid && S_AXIS_DATA_tready;

  assign w_push = (w_match && w_can_push) || w_term_push;

  always_comb begin
    w_push_data = '0;
    if (w_term_push) w_push_data = {1'b1, {OW{1'b1}}};
    else             w_push_data = {1'b0, VEC_ID_WIDTH'(r_k), r_cur_id};
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) r_state <= LOAD_REF;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD_REF: begin
        if (w_term_push)                                           w_state_nxt = LOAD_REF;
        else if (w_vec_pop && (r_ref_idx == KW'(SHR_DEPTH - 1)))   w_state_nxt = COMPARE;
      end
      COMPARE: begin
        if (w_term_push) w_state_nxt = LOAD_REF;
      end
    endcase
  end

  // Unpacker: new beats land above the current fill; vectors leave from bit 0.
  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) begin
      r_buf  <= '0;
      r_fill <= '0;
      r_eos  <= 1'b0;
      r_run  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_term_push) begin
        r_buf  <= '0;
        r_fill <= '0;
        r_eos  <= 1'b0;
      end else if (w_vec_pop) begin
        r_buf  <= r_buf >> VECTOR_WIDTH;
        r_fill <= r_fill - FILL_W'(VECTOR_WIDTH);
      end else if (w_beat_acc) begin
        r_buf  <= r_buf | (BUF_W'(S_AXIS_DATA_tdata) << r_fill);
        r_fill <= r_fill + FILL_W'(BUS_WIDTH);
        r_eos  <= S_AXIS_DATA_tlast;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) begin
      for (int k = 0; k < SHR_DEPTH; k++) begin
        r_ref[k] <= '0;
        r_pr[k]  <= '0;
      end
      r_ref_idx <= '0;
    end else if (w_term_push) begin
      r_ref_idx <= '0;
    end else if (w_vec_pop && (r_state == LOAD_REF)) begin
      r_ref[r_ref_idx] <= w_vec;
      r_pr[r_ref_idx]  <= w_vec_pc;
      if (r_ref_idx == KW'(SHR_DEPTH - 1)) r_ref_idx <= '0;
      else                                 r_ref_idx <= r_ref_idx + KW'(1);
    end
  end

  // Evaluator: one reference per cycle, held in place while a match cannot be pushed.
  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) begin
      r_cmp     <= '0;
      r_pc      <= '0;
      r_busy    <= 1'b0;
      r_k       <= '0;
      r_cur_id  <= '0;
      r_next_id <= '0;
    end else begin
      if (w_vec_pop && (r_state == COMPARE)) begin
        r_cmp     <= w_vec;
        r_pc      <= w_vec_pc;
        r_busy    <= 1'b1;
        r_k       <= '0;
        r_cur_id  <= r_next_id;
        r_next_id <= r_next_id + VEC_ID_WIDTH'(1);
      end else if (w_eval_adv) begin
        if (w_eval_last) begin
          r_busy <= 1'b0;
          r_k    <= '0;
        end else begin
          r_k <= r_k + KW'(1);
        end
      end
      if (w_term_push) r_next_id <= '0;
    end
  end

  // Output FIFO: shift-in register, head read at depth cnt-1.
  always_ff @(posedge ap_clk) begin
    if (w_push) begin
      r_fifo_mem[0] <= w_push_data;
      for (int i = 1; i < OUT_FIFO_DEPTH; i++) r_fifo_mem[i] <= r_fifo_mem[i-1];
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rstn) r_fifo_cnt <= '0;
    else          r_fifo_cnt <= r_fifo_cnt + FCW'(w_push) - FCW'(w_fifo_pop);
  end

  assign w_head_idx            = FAW'(r_fifo_cnt - FCW'(1));
  assign w_head                = r_fifo_mem[w_head_idx];
  assign M_AXIS_ID_PAIR_tvalid = (r_fifo_cnt != '0);
  assign M_AXIS_ID_PAIR_tdata  = w_head[OW-1:0];
  assign M_AXIS_ID_PAIR_tlast  = M_AXIS_ID_PAIR_tvalid && w_head[OW];

endmodule

// File: tb/tb_tanimoto_top_intf.sv
module tb_tanimoto_top_intf;
  localparam int BW  = 128;
  localparam int VW  = 920;
  localparam int SD  = 8;
  localparam int IDW = 8;
  localparam int CW  = 10;
  localparam int VB  = VW / 8;
  localparam int BB  = BW / 8;

  logic            ap_clk = 1'b0;
  logic            ap_rstn = 1'b0;
  logic [BW-1:0]   s_tdata = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tready;
  logic            s_tlast = 1'b0;
  logic [2*IDW-1:0] m_tdata;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic            m_tlast;
  logic            bram_rst = 1'b0;
  logic [CW-1:0]   bram_addr = '0;
  logic [CW:0]     bram_wrdata = '0;
  logic [CW:0]     bram_rddata;
  logic            bram_en = 1'b0;
  logic            bram_we = 1'b0;

  always #5 ap_clk = ~ap_clk;

  tanimoto_top_intf dut (
    .ap_clk                (ap_clk),
    .ap_rstn               (ap_rstn),
    .S_AXIS_DATA_tdata     (s_tdata),
    .S_AXIS_DATA_tvalid    (s_tvalid),
    .S_AXIS_DATA_tready    (s_tready),
    .S_AXIS_DATA_tlast     (s_tlast),
    .M_AXIS_ID_PAIR_tdata  (m_tdata),
    .M_AXIS_ID_PAIR_tvalid (m_tvalid),
    .M_AXIS_ID_PAIR_tready (m_tready),
    .M_AXIS_ID_PAIR_tlast  (m_tlast),
    .BRAM_PORTA_clk_a      (ap_clk),
    .BRAM_PORTA_rst_a      (bram_rst),
    .BRAM_PORTA_addr_a     (bram_addr),
    .BRAM_PORTA_wrdata_a   (bram_wrdata),
    .BRAM_PORTA_rddata_a   (bram_rddata),
    .BRAM_PORTA_en_a       (bram_en),
    .BRAM_PORTA_we_a       (bram_we)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW:0]   m_thr [0:(1<<CW)-1];
  logic [VW-1:0] g_vecs[$];
  logic [BW-1:0] g_beats[$];
  logic [16:0]   exp_q[$];
  logic [16:0]   got_q[$];
  bit            rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic thr_write(input int a, input int d);
    @(negedge ap_clk);
    bram_en = 1'b1; bram_we = 1'b1;
    bram_addr = CW'(a); bram_wrdata = (CW+1)'(d);
    m_thr[a] = (CW+1)'(d);
  endtask

  task automatic thr_idle();
    @(negedge ap_clk);
    bram_en = 1'b0; bram_we = 1'b0;
  endtask

  task automatic load_thr(input bit all_ones);
    int v;
    for (int c = 0; c <= VW; c++) begin
      v = all_ones ? 2047 : (c * 67) / 17;   // floor(c*1.34/0.34), saturated to table width
      if (v > 2047) v = 2047;
      thr_write(c, v);
    end
    thr_idle();
  endtask

  function automatic logic [VW-1:0] rand_vec(input int pct);
    logic [VW-1:0] v;
    for (int b = 0; b < VW; b++) v[b] = ($urandom_range(0, 99) < pct);
    return v;
  endfunction

  function automatic void pack_beats();
    int nbytes, nbeats, b;
    logic [BW-1:0] beat;
    logic [VW-1:0] v;
    nbytes = g_vecs.size() * VB;
    nbeats = (nbytes + BB - 1) / BB;
    g_beats.delete();
    for (int t = 0; t < nbeats; t++) begin
      for (int j = 0; j < BB; j++) begin
        b = t * BB + j;
        if (b < nbytes) begin
          v = g_vecs[b / VB];
          beat[8*j +: 8] = v[8*(b % VB) +: 8];
        end else begin
          beat[8*j +: 8] = 8'($urandom);
        end
      end
      g_beats.push_back(beat);
    end
  endfunction

  // Reference: every (ref k, compare c) pair in compare-major order, then the terminator.
  function automatic void build_expected();
    logic [VW-1:0] cv, rv;
    int pc, pr, i;
    exp_q.delete();
    for (int c = SD; c < g_vecs.size(); c++) begin
      cv = g_vecs[c];
      pc = $countones(cv);
      for (int k = 0; k < SD; k++) begin
        rv = g_vecs[k];
        pr = $countones(rv);
        i  = $countones(rv & cv);
        if (pr + pc <= int'(m_thr[i])) exp_q.push_back({1'b0, 8'(k), 8'(c - SD)});
      end
    end
    exp_q.push_back({1'b1, 16'hFFFF});
  endfunction

  task automatic send_stream(input int valid_every, input int limit);
    int idx, cyc;
    idx = 0; cyc = 0;
    while (idx < limit && cyc < 20000) begin
      @(negedge ap_clk);
      cyc++;
      s_tvalid = ((cyc % valid_every) == 0);
      s_tdata  = g_beats[idx];
      s_tlast  = (idx == g_beats.size() - 1);
      if (s_tvalid && s_tready) idx++;
    end
    @(negedge ap_clk);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    chk("send_done", idx, limit);
  endtask

  task automatic wait_term(input string tag);
    int cyc;
    logic [16:0] last_w;
    bit seen;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 4000) begin
      @(negedge ap_clk);
      cyc++;
      if (got_q.size() > 0) begin
        last_w = got_q[got_q.size() - 1];
        seen = last_w[16];
      end
    end
    chk({tag, "_term_seen"}, seen, 1);
    repeat (20) @(negedge ap_clk);
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  task automatic run_stream(input string tag, input int valid_every);
    got_q.delete();
    pack_beats();
    build_expected();
    send_stream(valid_every, g_beats.size());
    wait_term(tag);
    compare_out(tag);
  endtask

  // Output sink: drives tready, records transfers, checks hold-while-stalled.
  logic [16:0] prev_head;
  bit          prev_stall = 1'b0;
  initial begin
    forever begin
      @(negedge ap_clk);
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && ap_rstn)
        chk("hold_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_head});
      if (ap_rstn && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
      prev_stall = ap_rstn && m_tvalid && !m_tready;
      prev_head  = {m_tlast, m_tdata};
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, cnt01;
    logic [VW-1:0] r0, c1;

    // reset behaviour
    repeat (5) begin
      @(negedge ap_clk);
      chk("rst_tready", s_tready, 0);
      chk("rst_mvalid", m_tvalid, 0);
      chk("rst_mlast", m_tlast, 0);
    end
    chk("rst_rddata", bram_rddata, 0);
    ap_rstn = 1'b1;
    lat = 0;
    while (lat < 4 && !s_tready) begin
      @(negedge ap_clk);
      lat++;
    end
    chk("rst_tready_lat_ok", (lat >= 1 && lat <= 2), 1);

    // BRAM port: write, read, read-first, rst_a
    thr_write(5, 7);
    @(negedge ap_clk);
    bram_en = 1'b1; bram_we = 1'b0; bram_addr = CW'(5);
    @(negedge ap_clk);
    chk("bram_read5", bram_rddata, 7);
    bram_we = 1'b1; bram_wrdata = (CW+1)'(9);
    @(negedge ap_clk);
    chk("bram_read_first", bram_rddata, 7);
    bram_we = 1'b0;
    @(negedge ap_clk);
    chk("bram_read_new", bram_rddata, 9);
    bram_rst = 1'b1;
    @(negedge ap_clk);
    chk("bram_rst_a", bram_rddata, 0);
    bram_rst = 1'b0; bram_en = 1'b0;

    // stream 1: directed identical / disjoint compare vectors
    load_thr(1'b0);
    chk("thr100_model", m_thr[100], 394);
    r0 = '0; c1 = '0;
    for (int b = 0; b < 100; b++) begin r0[b] = 1'b1; c1[b + 100] = 1'b1; end
    g_vecs.delete();
    g_vecs.push_back(r0);
    for (int k = 1; k < SD; k++) g_vecs.push_back('0);
    g_vecs.push_back(r0);
    g_vecs.push_back(c1);
    run_stream("s1", 1);
    chk("s1_pair00", (got_q.size() > 0) ? got_q[0] : 17'h1FFFF, 17'h00000);
    cnt01 = 0;
    foreach (got_q[i]) if (got_q[i] == 17'h00001) cnt01++;
    chk("s1_no_pair01", cnt01, 0);

    // stream 2: 8 refs + 24 random compares, some compares copied from refs
    g_vecs.delete();
    for (int k = 0; k < SD; k++) g_vecs.push_back(rand_vec($urandom_range(15, 85)));
    for (int c = 0; c < 24; c++) begin
      if (c % 4 == 0) g_vecs.push_back(g_vecs[c % SD]);
      else            g_vecs.push_back(rand_vec($urandom_range(5, 60)));
    end
    run_stream("s2", 1);

    // stream 3: same vectors, tvalid 1 cycle in 4
    run_stream("s3", 4);

    // stream 4: everything matches, random output backpressure
    load_thr(1'b1);
    rand_ready = 1'b1;
    run_stream("s4", 1);
    chk("s4_count", got_q.size(), 193);
    rand_ready = 1'b0;

    // stream 5: tlast while still loading references
    g_vecs.delete();
    for (int k = 0; k < 3; k++) g_vecs.push_back(rand_vec(50));
    run_stream("s5", 1);

    // mid-stream reset discards the partial stream
    g_vecs.delete();
    for (int k = 0; k < 32; k++) g_vecs.push_back(rand_vec(50));
    pack_beats();
    send_stream(1, 100);
    repeat (3) begin
      @(negedge ap_clk);
      ap_rstn = 1'b0;
    end
    @(negedge ap_clk);
    chk("mrst_mvalid", m_tvalid, 0);
    chk("mrst_tready", s_tready, 0);
    ap_rstn = 1'b1;
    repeat (3) @(negedge ap_clk);
    g_vecs.delete();
    g_vecs.push_back(r0);
    for (int k = 1; k < SD; k++) g_vecs.push_back('0);
    g_vecs.push_back(r0);
    g_vecs.push_back(c1);
    run_stream("s6", 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
